ip_pack: RTL and testbench

IP_PACK -- requirements
Module: ip_pack

---
 rtl/ip_pack_pkg.sv | 27 ++
 rtl/ip_pack_fifo.sv | 72 +++++++
 rtl/ip_pack_hdr_csum.sv | 38 +++
 rtl/ip_pack.sv | 178 +++++++++++++++++
 tb/tb_ip_pack.sv | 255 +++++++++++++++++++++++++
 5 files changed

// File: rtl/ip_pack_pkg.sv
// Shared constants, state encoding and checksum folding for the IPv4 header packer.
package ip_pack_pkg;

    localparam logic [7:0]  HDR_VER_IHL    = 8'h45;
    localparam logic [7:0]  HDR_TOS        = 8'h00;
    localparam logic [15:0] HDR_FLAGS_FRAG = 16'h4000;
    localparam int          HDR_LEN        = 20;
    localparam logic [15:0] HDR_LEN_W      = 16'd20;
    localparam int          HDR_WORDS      = 10;
    localparam int          FIFO_W         = 9;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CSUM,
        ST_HEAD,
        ST_DATA
    } state_t;

    // Two end-around-carry folds of a 32-bit sum, then ones'-complement.
    // After the first fold the carry is at most 1, so the second add cannot overflow.
    function automatic logic [15:0] csum_fold(input logic [31:0] sum);
        logic [31:0] s1;
        s1 = {16'h0, sum[31:16]} + {16'h0, sum[15:0]};
        return ~(s1[15:0] + s1[31:16]);
    endfunction

endpackage

// File: rtl/ip_pack_fifo.sv
// Synchronous show-ahead FIFO; RAM read is registered with a one-cycle write bypass.
module ip_pack_fifo #(
    parameter int WIDTH = 9,
    parameter int DEPTH = 16
) (
    input  logic             clk,
    input  logic             srst_i,
    input  logic             wr_en_i,
    input  logic [WIDTH-1:0] wr_data_i,
    input  logic             rd_en_i,
    output logic [WIDTH-1:0] rd_data_o,
    output logic             empty_o
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic [WIDTH-1:0] ram_rd_q;
    logic [WIDTH-1:0] byp_data_q;
    logic             byp_q;
    logic             full;
    logic             wr_ok;
    logic             rd_ok;

    function automatic logic [AW-1:0] next_ptr(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
    endfunction

    assign full      = (count_q == (AW+1)'(DEPTH));
    assign empty_o   = (count_q == '0);
    assign wr_ok     = wr_en_i && !full;
    assign rd_ok     = rd_en_i && !empty_o;
    assign rd_data_o = byp_q ? byp_data_q : ram_rd_q;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (wr_ok) wr_ptr_d = next_ptr(wr_ptr_q);
        if (rd_ok) rd_ptr_d = next_ptr(rd_ptr_q);
        if (wr_ok && !rd_ok) begin
            count_d = count_q + (AW+1)'(1);
        end else if (!wr_ok && rd_ok) begin
            count_d = count_q - (AW+1)'(1);
        end
    end

    // Read address is the next head so the head word is always pre-fetched.
    always_ff @(posedge clk) begin
        if (wr_ok) mem[wr_ptr_q] <= wr_data_i;
        ram_rd_q   <= mem[rd_ptr_d];
        byp_data_q <= wr_data_i;
    end

    always_ff @(posedge clk) begin
        if (srst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            byp_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            byp_q    <= wr_ok && (wr_ptr_q == rd_ptr_d);
        end
    end

endmodule

// File: rtl/ip_pack_hdr_csum.sv
// Combinational IPv4 header checksum over the ten header words (checksum word as zero).
module ip_hdr_csum
    import ip_pack_pkg::*;
#(
    parameter logic [7:0] TTL   = 8'h40,
    parameter logic [7:0] PROTO = 8'h11
) (
    input  logic [15:0] total_len_i,
    input  logic [15:0] id_i,
    input  logic [31:0] sour_ip_i,
    input  logic [31:0] dest_ip_i,
    output logic [15:0] csum_o
);

    logic [15:0] words [HDR_WORDS];
    logic [31:0] sum;

    assign words[0] = {HDR_VER_IHL, HDR_TOS};
    assign words[1] = total_len_i;
    assign words[2] = id_i;
    assign words[3] = HDR_FLAGS_FRAG;
    assign words[4] = {TTL, PROTO};
    assign words[5] = 16'h0000;
    assign words[6] = sour_ip_i[31:16];
    assign words[7] = sour_ip_i[15:0];
    assign words[8] = dest_ip_i[31:16];
    assign words[9] = dest_ip_i[15:0];

    always_comb begin
        sum = '0;
        for (int i = 0; i < HDR_WORDS; i++) begin
            sum = sum + {16'h0, words[i]};
        end
    end

    assign csum_o = csum_fold(sum);

endmodule

// File: rtl/ip_pack.sv
// IPv4 packer: buffers UDP segments, then emits a 20-byte IPv4 header followed by the payload.
module ip_pack
    import ip_pack_pkg::*;
#(
    parameter int         DATA_DEPTH = 4096,
    parameter int         LEN_DEPTH  = 16,
    parameter logic [7:0] TTL        = 8'h40,
    parameter logic [7:0] PROTO      = 8'h11
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] sour_ip,
    input  logic [31:0] dest_ip,
    input  logic [7:0]  din,
    input  logic        din_vld,
    input  logic        din_sop,
    input  logic        din_eop,
    output logic [7:0]  dout,
    output logic        dout_vld,
    output logic        dout_sop,
    output logic        dout_eop
);

    state_t      state_q, state_d;
    logic [4:0]  hcnt_q, hcnt_d;
    logic [15:0] len_q, len_d;
    logic [15:0] csum_q, csum_d;
    logic [15:0] id_q, id_d;
    logic [15:0] byte_cnt_q, byte_cnt_d;
    logic [7:0]  dout_q, dout_d;
    logic        vld_q, vld_d;
    logic        sop_q, sop_d;
    logic        eop_q, eop_d;

    logic [15:0]       seg_len;
    logic [15:0]       total_len;
    logic [15:0]       csum_calc;
    logic [15:0]       len_head;
    logic              len_empty;
    logic              len_pop;
    logic [FIFO_W-1:0] data_head;
    logic              data_empty;
    logic              data_pop;

    logic [HDR_LEN*8-1:0] hdr_vec;
    logic [7:0]           hdr_bytes [HDR_LEN];

    // Length including the byte being accepted this cycle.
    assign seg_len    = din_sop ? 16'd1 : byte_cnt_q + 16'd1;
    assign byte_cnt_d = din_vld ? seg_len : byte_cnt_q;
    assign total_len  = len_q + HDR_LEN_W;

    ip_pack_fifo #(
        .WIDTH (FIFO_W),
        .DEPTH (DATA_DEPTH)
    ) u_data_fifo (
        .clk       (clk),
        .srst_i    (rst),
        .wr_en_i   (din_vld),
        .wr_data_i ({din_eop, din}),
        .rd_en_i   (data_pop),
        .rd_data_o (data_head),
        .empty_o   (data_empty)
    );

    ip_pack_fifo #(
        .WIDTH (16),
        .DEPTH (LEN_DEPTH)
    ) u_len_fifo (
        .clk       (clk),
        .srst_i    (rst),
        .wr_en_i   (din_vld && din_eop),
        .wr_data_i (seg_len),
        .rd_en_i   (len_pop),
        .rd_data_o (len_head),
        .empty_o   (len_empty)
    );

    ip_hdr_csum #(
        .TTL   (TTL),
        .PROTO (PROTO)
    ) u_csum (
        .total_len_i (total_len),
        .id_i        (id_q),
        .sour_ip_i   (sour_ip),
        .dest_ip_i   (dest_ip),
        .csum_o      (csum_calc)
    );

    assign hdr_vec = {HDR_VER_IHL, HDR_TOS, total_len, id_q, HDR_FLAGS_FRAG,
                      TTL, PROTO, csum_q, sour_ip, dest_ip};

    // Byte 0 is the most significant byte of the header vector.
    for (genvar gi = 0; gi < HDR_LEN; gi++) begin : g_hdr_bytes
        assign hdr_bytes[gi] = hdr_vec[(HDR_LEN-1-gi)*8 +: 8];
    end

    always_comb begin
        state_d  = state_q;
        hcnt_d   = hcnt_q;
        len_d    = len_q;
        csum_d   = csum_q;
        id_d     = id_q;
        len_pop  = 1'b0;
        data_pop = 1'b0;
        dout_d   = '0;
        vld_d    = 1'b0;
        sop_d    = 1'b0;
        eop_d    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!len_empty) begin
                    len_d   = len_head;
                    len_pop = 1'b1;
                    state_d = ST_CSUM;
                end
            end
            ST_CSUM: begin
                csum_d  = csum_calc;
                hcnt_d  = '0;
                state_d = ST_HEAD;
            end
            ST_HEAD: begin
                dout_d = hdr_bytes[hcnt_q];
                vld_d  = 1'b1;
                sop_d  = (hcnt_q == '0);
                hcnt_d = hcnt_q + 5'd1;
                if (hcnt_q == 5'(HDR_LEN - 1)) state_d = ST_DATA;
            end
            ST_DATA: begin
                // The whole segment is already buffered, so the FIFO only runs dry on upstream misuse.
                if (!data_empty) begin
                    data_pop = 1'b1;
                    dout_d   = data_head[7:0];
                    vld_d    = 1'b1;
                    if (data_head[FIFO_W-1]) begin
                        eop_d   = 1'b1;
                        id_d    = id_q + 16'd1;
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            hcnt_q     <= '0;
            len_q      <= '0;
            csum_q     <= '0;
            id_q       <= '0;
            byte_cnt_q <= '0;
            dout_q     <= '0;
            vld_q      <= 1'b0;
            sop_q      <= 1'b0;
            eop_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            hcnt_q     <= hcnt_d;
            len_q      <= len_d;
            csum_q     <= csum_d;
            id_q       <= id_d;
            byte_cnt_q <= byte_cnt_d;
            dout_q     <= dout_d;
            vld_q      <= vld_d;
            sop_q      <= sop_d;
            eop_q      <= eop_d;
        end
    end

    assign dout     = dout_q;
    assign dout_vld = vld_q;
    assign dout_sop = sop_q;
    assign dout_eop = eop_q;

endmodule

// File: tb/tb_ip_pack.sv
// Directed bench for ip_pack with a byte-level scoreboard and per-datagram timing records.
module tb_ip_pack;

    typedef struct packed {
        logic       sop;
        logic       eop;
        logic [7:0] data;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] sour_ip = 32'hC0A80001;
    logic [31:0] dest_ip = 32'hC0A80002;
    logic [7:0]  din = '0;
    logic        din_vld = 1'b0;
    logic        din_sop = 1'b0;
    logic        din_eop = 1'b0;
    logic [7:0]  dout;
    logic        dout_vld;
    logic        dout_sop;
    logic        dout_eop;

    int checks = 0;
    int errors = 0;

    exp_t        sb [$];
    logic [15:0] exp_id = 16'h0000;
    logic [159:0] lit_hdr = 160'h4500001C_00004000_4011B97D_C0A80001_C0A80002;

    int          edge_idx = 0;
    int          last_in_eop = 0;
    int          pkt_cnt = 0;
    int          run_len = 0;
    int          byte_idx = 0;
    int          eop_out_edge = 0;
    bit          have_eop = 0;
    bit          prev_vld = 0;
    bit          prev_eop = 0;
    logic [15:0] cap_id = '0;
    int          sop_edge_arr [32];
    int          gap_arr [32];
    int          run_arr [32];
    logic [15:0] id_arr [32];

    ip_pack dut (
        .clk      (clk),
        .rst      (rst),
        .sour_ip  (sour_ip),
        .dest_ip  (dest_ip),
        .din      (din),
        .din_vld  (din_vld),
        .din_sop  (din_sop),
        .din_eop  (din_eop),
        .dout     (dout),
        .dout_vld (dout_vld),
        .dout_sop (dout_sop),
        .dout_eop (dout_eop)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    always @(posedge clk) begin
        edge_idx++;
        if (din_vld && din_eop) last_in_eop = edge_idx;
    end

    // Output monitor: pops the scoreboard and records per-datagram timing.
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            prev_vld = 0;
            prev_eop = 0;
            run_len  = 0;
        end else begin
            if (dout_vld) begin
                if (dout_sop) begin
                    run_len  = 1;
                    byte_idx = 0;
                    sop_edge_arr[pkt_cnt] = edge_idx;
                    gap_arr[pkt_cnt] = have_eop ? (edge_idx - eop_out_edge - 1) : -1;
                end else begin
                    chk("vld_contiguous", 32'(prev_vld), 32'd1);
                    run_len++;
                    byte_idx++;
                end
                if (byte_idx == 4) cap_id[15:8] = dout;
                if (byte_idx == 5) cap_id[7:0]  = dout;
                if (sb.size() == 0) begin
                    chk("sb_underflow", 32'(sb.size()), 32'd1);
                end else begin
                    e = sb.pop_front();
                    chk("sb_byte", {22'd0, dout_sop, dout_eop, dout}, {22'd0, e.sop, e.eop, e.data});
                end
                if (dout_eop) begin
                    run_arr[pkt_cnt] = run_len;
                    id_arr[pkt_cnt]  = cap_id;
                    eop_out_edge     = edge_idx;
                    have_eop         = 1;
                    $display("datagram %0d id=%h len=%0d", pkt_cnt, cap_id, run_len);
                    pkt_cnt++;
                end
            end else if (prev_vld) begin
                chk("eop_before_drop", 32'(prev_eop), 32'd1);
            end
            prev_vld = dout_vld;
            prev_eop = dout_eop;
        end
    end

    // Pushes the expected header (model or literal) and drives the segment bytes.
    task automatic send_seg(input int n, input bit gappy, input logic [7:0] seed, input bit lit);
        logic [7:0]  h [20];
        logic [15:0] total;
        logic [15:0] ck;
        int unsigned s;
        total = 16'(n + 20);
        h[0] = 8'h45; h[1] = 8'h00; h[2] = total[15:8]; h[3] = total[7:0];
        h[4] = exp_id[15:8]; h[5] = exp_id[7:0]; h[6] = 8'h40; h[7] = 8'h00;
        h[8] = 8'h40; h[9] = 8'h11; h[10] = 8'h00; h[11] = 8'h00;
        h[12] = sour_ip[31:24]; h[13] = sour_ip[23:16]; h[14] = sour_ip[15:8]; h[15] = sour_ip[7:0];
        h[16] = dest_ip[31:24]; h[17] = dest_ip[23:16]; h[18] = dest_ip[15:8]; h[19] = dest_ip[7:0];
        s = 0;
        for (int i = 0; i < 20; i += 2) s += {16'h0, h[i], h[i+1]};
        while (s > 32'hFFFF) s = (s & 32'hFFFF) + (s >> 16);
        ck = ~s[15:0];
        h[10] = ck[15:8];
        h[11] = ck[7:0];
        if (lit) begin
            for (int i = 0; i < 20; i++) h[i] = lit_hdr[159-8*i -: 8];
        end
        for (int i = 0; i < 20; i++) sb.push_back('{sop: (i == 0), eop: 1'b0, data: h[i]});
        exp_id = exp_id + 16'd1;
        for (int i = 0; i < n; i++) begin
            if (gappy) begin
                @(negedge clk);
                din_vld = 1'b0; din_sop = 1'b0; din_eop = 1'b0;
            end
            @(negedge clk);
            din     = seed + 8'(i * 7);
            din_vld = 1'b1;
            din_sop = (i == 0);
            din_eop = (i == n - 1);
            sb.push_back('{sop: 1'b0, eop: (i == n - 1), data: din});
        end
        @(negedge clk);
        din_vld = 1'b0; din_sop = 1'b0; din_eop = 1'b0;
    endtask

    task automatic wait_pkts(input int target);
        int n;
        n = 0;
        while (pkt_cnt < target && n < 3000) begin
            @(negedge clk);
            n++;
        end
        chk("pkt_count", 32'(pkt_cnt), 32'(target));
    endtask

    // Call at a negedge; asserts rst for one edge and checks the cleared outputs.
    task automatic do_reset(input string tag);
        #1 rst = 1'b1;
        @(negedge clk);
        chk({tag, "_dout"}, {24'd0, dout}, 32'd0);
        chk({tag, "_vld"}, {31'd0, dout_vld}, 32'd0);
        chk({tag, "_sop"}, {31'd0, dout_sop}, 32'd0);
        chk({tag, "_eop"}, {31'd0, dout_eop}, 32'd0);
        #1 rst = 1'b0;
        sb.delete();
        exp_id = 16'h0000;
    endtask

    initial begin
        int eop0;
        int n;

        @(negedge clk);
        do_reset("reset");

        // Checksum reference datagram
        send_seg(8, 1'b0, 8'h10, 1'b1);
        wait_pkts(1);
        chk("csum_run_len", 32'(run_arr[0]), 32'd28);

        // Single-byte segment
        send_seg(1, 1'b0, 8'hA5, 1'b0);
        wait_pkts(2);
        chk("one_byte_run_len", 32'(run_arr[1]), 32'd21);

        // Three back-to-back segments after a fresh reset
        @(negedge clk);
        do_reset("reset2");
        send_seg(8, 1'b0, 8'h30, 1'b0);
        eop0 = last_in_eop;
        send_seg(8, 1'b0, 8'h50, 1'b0);
        send_seg(8, 1'b0, 8'h70, 1'b0);
        wait_pkts(5);
        chk("b2b_latency", 32'(sop_edge_arr[2] - eop0), 32'd3);
        chk("b2b_gap1", 32'(gap_arr[3]), 32'd2);
        chk("b2b_gap2", 32'(gap_arr[4]), 32'd2);
        chk("b2b_id0", {16'd0, id_arr[2]}, 32'h0000);
        chk("b2b_id1", {16'd0, id_arr[3]}, 32'h0001);
        chk("b2b_id2", {16'd0, id_arr[4]}, 32'h0002);

        // Gappy 64-byte input
        sour_ip = 32'h0A000001;
        dest_ip = 32'h0A0000FE;
        send_seg(64, 1'b1, 8'h03, 1'b0);
        wait_pkts(6);
        chk("gappy_run_len", 32'(run_arr[5]), 32'd84);

        // ID wrap
        @(negedge clk);
        force dut.id_q = 16'hFFFF;
        @(negedge clk);
        release dut.id_q;
        exp_id = 16'hFFFF;
        send_seg(4, 1'b0, 8'hC0, 1'b0);
        send_seg(4, 1'b0, 8'hD0, 1'b0);
        wait_pkts(8);
        chk("wrap_id_ffff", {16'd0, id_arr[6]}, 32'h0000FFFF);
        chk("wrap_id_0000", {16'd0, id_arr[7]}, 32'h00000000);

        // Reset at the 10th header byte, then a clean datagram
        sour_ip = 32'hC0A80001;
        dest_ip = 32'hC0A80002;
        send_seg(8, 1'b0, 8'h21, 1'b0);
        n = 0;
        while (dout_sop !== 1'b1 && n < 500) begin
            @(negedge clk);
            n++;
        end
        chk("abort_sop_seen", {31'd0, dout_sop}, 32'd1);
        repeat (9) @(negedge clk);
        do_reset("abort");
        send_seg(8, 1'b0, 8'h44, 1'b0);
        wait_pkts(9);
        chk("post_reset_id", {16'd0, id_arr[8]}, 32'h0000);
        chk("post_reset_run_len", 32'(run_arr[8]), 32'd28);

        repeat (5) @(negedge clk);
        chk("sb_empty", 32'(sb.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
